// File: rtl/ps2_key_ctrl.sv
// PS/2 FIFO read sequencer and scan-code decoder.
// Folds E0/F0 prefixes into make/repeat/release events.
module ps2_key_ctrl #(
  parameter int CNT_W  = 8,
  parameter int TO_W   = 16,
  parameter int PFX_TO = 50000
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_repeat,
  output logic             key_release,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PFX_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP
  } state_t;

  typedef enum logic [2:0] {
    D_EXT,
    D_BRK,
    D_BAD,
    D_REL,
    D_REP,
    D_MAKE
  } dec_t;

  state_t          state;
  state_t          state_nx;
  dec_t            dec;
  logic [7:0]      byte_q;
  logic            ext_pend;
  logic            brk_pend;
  logic [7:0]      held_code;
  logic            held_ext;
  logic [TO_W-1:0] to_cnt;
  logic            to_run;
  logic            hit;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (ready) state_nx = POP;
      POP:     state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign nextdata_n = (state != POP);

  assign hit = key_held
            && (held_code == byte_q)
            && (held_ext == ext_pend);

  assign to_run = (ext_pend | brk_pend)
               && (state == IDLE)
               && !ready;

  // Classify the latched byte; order sets priority.
  always_comb begin
    dec = D_MAKE;
    if (byte_q == 8'hE0)
      dec = D_EXT;
    else if (byte_q == 8'hF0)
      dec = D_BRK;
    else if (byte_q == 8'h00 || byte_q == 8'hFF)
      dec = D_BAD;
    else if (brk_pend)
      dec = D_REL;
    else if (hit)
      dec = D_REP;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      byte_q      <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      held_code   <= '0;
      held_ext    <= 1'b0;
      to_cnt      <= '0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_make    <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
      press_count <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      key_make    <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      if (state == IDLE && ready)
        byte_q <= data;
      if (overflow)
        err <= 1'b1;
      if (state == POP) begin
        to_cnt <= '0;
      end else if (to_run) begin
        if (to_cnt == TO_LAST) begin
          to_cnt   <= '0;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (state == GAP) begin
        unique case (dec)
          D_EXT: ext_pend <= 1'b1;
          D_BRK: brk_pend <= 1'b1;
          D_BAD: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            err      <= 1'b1;
          end
          D_REL: begin
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_release <= 1'b1;
            key_code    <= byte_q;
            key_ext     <= ext_pend;
            if (hit) key_held <= 1'b0;
          end
          D_REP: begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            key_repeat <= 1'b1;
            key_code   <= byte_q;
            key_ext    <= ext_pend;
          end
          default: begin
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_make    <= 1'b1;
            key_held    <= 1'b1;
            key_code    <= byte_q;
            key_ext     <= ext_pend;
            held_code   <= byte_q;
            held_ext    <= ext_pend;
            press_count <= press_count + 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: FIFO model feeds bytes,
// a monitor checks each event pulse against queued expectations.
module tb_ps2_key_ctrl;

  localparam int PTO = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] data = '0;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_make;
  logic       key_repeat;
  logic       key_release;
  logic       key_held;
  logic [7:0] press_count;
  logic       err;

  ps2_key_ctrl #(
    .CNT_W (8),
    .TO_W  (16),
    .PFX_TO(PTO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .nextdata_n (nextdata_n),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_make   (key_make),
    .key_repeat (key_repeat),
    .key_release(key_release),
    .key_held   (key_held),
    .press_count(press_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MK = 3'b100;
  localparam logic [2:0] RP = 3'b010;
  localparam logic [2:0] RL = 3'b001;

  logic [7:0]  fifo[$];
  logic [20:0] exp_q[$];
  int          npass = 0;
  int          ntot = 0;
  int          pops = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // FIFO model: pop at the negedge inside the POP cycle.
  always @(negedge clk) begin
    if (clrn && !nextdata_n && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pops++;
    end
    ready = (fifo.size() != 0);
    data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (clrn && (key_make | key_repeat | key_release)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected event",
            {11'd0, key_make, key_repeat, key_release,
             key_ext, key_held, key_code, press_count}, 0);
      end else begin
        chk("event",
            {11'd0, key_make, key_repeat, key_release,
             key_ext, key_held, key_code, press_count},
            {11'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic ev(logic [2:0] k, logic [7:0] c, logic x,
                    logic h, logic [7:0] n);
    exp_q.push_back({k, x, h, c, n});
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((fifo.size() != 0 || !nextdata_n) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {key_code, key_ext, key_make, key_repeat, key_release,
         key_held, press_count, err}, 0);
    chk("reset nextdata_n", nextdata_n, 1);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    p0 = pops;
    ev(MK, 8'h1C, 0, 1, 8'd1);
    send(8'h1C);
    drain(50);
    chk("single pop", pops - p0, 1);

    ev(RP, 8'h1C, 0, 1, 8'd1);
    ev(RP, 8'h1C, 0, 1, 8'd1);
    ev(RL, 8'h1C, 0, 0, 8'd1);
    send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain(100);
    chk("held after release", key_held, 0);

    ev(MK, 8'h75, 1, 1, 8'd2);
    ev(RL, 8'h75, 1, 0, 8'd2);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain(100);

    send(8'hF0);
    drain(50);
    repeat (PTO + 5) @(negedge clk);
    ev(MK, 8'h1C, 0, 1, 8'd3);
    send(8'h1C);
    drain(50);

    send(8'hF0);
    drain(50);
    repeat (5) @(negedge clk);
    ev(RL, 8'h1C, 0, 0, 8'd3);
    send(8'h1C);
    drain(50);

    for (int i = 0; i < 252; i++) begin
      ev(MK, (i % 2 == 0) ? 8'h15 : 8'h16, 0, 1, 8'(4 + i));
      send((i % 2 == 0) ? 8'h15 : 8'h16);
    end
    drain(1200);
    chk("count at ff", press_count, 8'hFF);

    ev(MK, 8'h2A, 0, 1, 8'h00);
    send(8'h2A);
    ev(RL, 8'h15, 0, 1, 8'h00);
    send(8'hF0); send(8'h15);
    ev(RP, 8'h2A, 0, 1, 8'h00);
    send(8'h2A);
    drain(100);
    chk("err before bad byte", err, 0);

    send(8'hFF);
    drain(50);
    chk("err after FF", err, 1);
    ev(RP, 8'h2A, 0, 1, 8'h00);
    send(8'hF0); send(8'h00); send(8'h2A);
    drain(100);

    send(8'h1C);
    begin
      int n = 0;
      while (nextdata_n && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("pop wait timeout", 0, 1);
    end
    clrn = 1'b0;
    #1;
    chk("reset in POP nextdata_n", nextdata_n, 1);
    chk("reset in POP outputs",
        {key_code, key_ext, key_make, key_repeat, key_release,
         key_held, press_count, err}, 0);
    @(negedge clk);
    fifo.delete();
    @(negedge clk);
    clrn = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle after reset", nextdata_n, 1);
    chk("no decode after reset", key_held, 0);

    ev(MK, 8'h1C, 0, 1, 8'd1);
    send(8'h1C);
    drain(50);
    chk("err clear after reset", err, 0);
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    @(negedge clk);
    chk("err on overflow", err, 1);

    chk("scoreboard empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
